// File: rtl/booth_seq_controller_if.sv
// Operand/result handshake and Booth table bus between booth_seq_controller (master) and its environment (slave).
// The table path (booth_sel/booth_seg* out, booth_tbl back) is purely combinational.
interface booth_seq_controller_if #(
  parameter int Width = 16
);
  logic               start;
  logic [Width-1:0]   multiplicand;
  logic [Width-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*Width-1:0] product;
  logic [1:0]         booth_sel;
  logic [Width:0]     booth_seg0;
  logic [Width:0]     booth_seg1;
  logic [Width:0]     booth_tbl;

  modport master (
    input  start, multiplicand, multiplier, booth_tbl,
    output busy, done, product, booth_sel, booth_seg0, booth_seg1
  );

  modport slave (
    output start, multiplicand, multiplier, booth_tbl,
    input  busy, done, product, booth_sel, booth_seg0, booth_seg1
  );
endinterface

// File: rtl/booth_seq_controller.sv
// Sequential radix-2 Booth multiplier: start accepted in IDLE, done/product Width+1 cycles later; start ignored while busy.
// Define BOOTH_INTERNAL_TABLE_EN to use the built-in Booth table; otherwise booth_tbl from the external mux is summed.
module booth_seq_controller #(
  parameter int Width = 16
) (
  input logic                    clk,
  input logic                    rst,
  booth_seq_controller_if.master bus
);
  localparam int CntW = $clog2(Width) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [Width:0]     a_q;
  logic [Width:0]     m_q;
  logic [Width-1:0]   q_q;
  logic               qm1_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*Width-1:0] product_q;

  logic               busy;
  logic               done;
  logic [1:0]         sel;
  logic               last_step;
  logic [Width:0]     neg_m;
  logic [Width:0]     tbl;
  logic [Width:0]     sum;
  logic [Width:0]     a_nxt;
  logic [Width-1:0]   q_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign last_step = (cnt_q == CntW'(1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    sel       = 2'b00;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        sel = {q_q[0], qm1_q};
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign neg_m = -m_q;

`ifdef BOOTH_INTERNAL_TABLE_EN
  always_comb begin
    case (sel)
      2'b01:   tbl = m_q;
      2'b10:   tbl = neg_m;
      default: tbl = '0;
    endcase
  end
`else
  assign tbl = bus.booth_tbl;
`endif

  // One Booth step: add the selected entry, then arithmetic shift {A,Q,Q_-1} right by one.
  assign sum   = a_q + tbl;
  assign a_nxt = {sum[Width], sum[Width:1]};
  assign q_nxt = {sum[0], q_q[Width-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_q   <= {bus.multiplicand[Width-1], bus.multiplicand};
            q_q   <= bus.multiplier;
            a_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= CntW'(Width);
          end
        end
        RUN: begin
          a_q   <= a_nxt;
          q_q   <= q_nxt;
          qm1_q <= q_q[0];
          cnt_q <= cnt_q - CntW'(1);
          if (last_step) product_q <= {a_nxt[Width-1:0], q_nxt};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.product    = product_q;
  assign bus.booth_sel  = sel;
  assign bus.booth_seg0 = m_q;
  assign bus.booth_seg1 = neg_m;
endmodule
